// File: rtl/snake_pkg.sv
// Shared snake-game types and constants: play-state encoding, grid size and the
// level-to-step-period helper used by the game controller.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int unsigned GRID_W     = 20;
    localparam int unsigned GRID_H     = 20;
    localparam int unsigned GRID_CELLS = GRID_W * GRID_H;

    // Step period for a level, floored at min_clk; the subtraction is only taken once it is known not to underflow.
    function automatic int unsigned step_period(input int unsigned lvl,
                                                input int unsigned base_clk,
                                                input int unsigned step_clk,
                                                input int unsigned min_clk);
        int unsigned drop;
        drop = lvl * step_clk;
        if (base_clk > min_clk && (base_clk - min_clk) > drop)
            return base_clk - drop;
        return min_clk;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable period counter: one-cycle tick after every `period` enabled cycles.
// `clr` restarts the count from zero; a disabled counter holds its value.
module tick_divider #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] period,
    input  logic         en,
    input  logic         clr,
    output logic         tick
);

    logic [W-1:0] count;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    // The >= compare lets a freshly shortened period fire on the very next enabled cycle.
    always_ff @(posedge clk) begin
        tick <= 1'b0;
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (count >= period - W'(1)) begin
                count <= '0;
                tick  <= 1'b1;
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/snake_ctrl.sv
// Snake game controller: play-state FSM, level-scaled step timer, score/level and seed capture.
// Define SNAKE_CTRL_LIVES_EN to add the lives counter and the `lives` output port.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_BASE_CLK  = 12000000,
    parameter int unsigned TICK_STEP_CLK  = 1000000,
    parameter int unsigned TICK_MIN_CLK   = 3000000,
    parameter int unsigned FOOD_PER_LEVEL = 5,
    parameter int unsigned MAX_LEVEL      = 9,
    parameter int          SCORE_W        = 10,
    parameter int unsigned SEED_MOD       = GRID_CELLS,
    parameter int unsigned LIVES          = 3,
    localparam int LEVEL_W = $clog2(MAX_LEVEL + 1),
    localparam int SEED_W  = (SEED_MOD > 1) ? $clog2(SEED_MOD) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               key_pressed,
    input  logic               food_eaten,
    input  logic               collision,
    output logic               step,
    output logic               restart,
    output state_t             state,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic [SEED_W-1:0]  seed
`ifdef SNAKE_CTRL_LIVES_EN
    ,
    output logic [$clog2(LIVES + 1)-1:0] lives
`endif
);

    localparam int unsigned TICK_MAX = (TICK_BASE_CLK > TICK_MIN_CLK) ? TICK_BASE_CLK : TICK_MIN_CLK;
    localparam int TICK_W = $clog2(TICK_MAX + 1);
    localparam int FOOD_W = (FOOD_PER_LEVEL > 1) ? $clog2(FOOD_PER_LEVEL) : 1;

    if (TICK_MIN_CLK < 2 || LIVES < 1) begin : g_bad_params
        $error("snake_ctrl: TICK_MIN_CLK must be >= 2 and LIVES >= 1");
    end

    logic [FOOD_W-1:0] food_cnt;
    logic [SEED_W-1:0] seed_cnt;
    logic [TICK_W-1:0] period;
    logic              food_wrap;
    logic              life_lost;
    logic              timer_en;
    logic              timer_clr;

`ifdef SNAKE_CTRL_LIVES_EN
    localparam int LIVES_W = $clog2(LIVES + 1);
    assign life_lost = (state == RUN) && collision && (lives > LIVES_W'(1));
`else
    assign life_lost = 1'b0;
`endif

    assign food_wrap = (food_cnt == FOOD_W'(FOOD_PER_LEVEL - 1));
    assign period    = TICK_W'(step_period(32'(level), TICK_BASE_CLK, TICK_STEP_CLK, TICK_MIN_CLK));
    // A collision cycle never emits a step: the snake either stops or is restarted.
    assign timer_en  = (state == RUN) && !start && !collision;
    assign timer_clr = start || life_lost;

    tick_divider #(
        .W (TICK_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .period (period),
        .en     (timer_en),
        .clr    (timer_clr),
        .tick   (step)
    );

    always_ff @(posedge clk) begin
        restart <= 1'b0;
        if (rst) begin
            state    <= IDLE;
            score    <= '0;
            level    <= '0;
            food_cnt <= '0;
`ifdef SNAKE_CTRL_LIVES_EN
            lives    <= LIVES_W'(LIVES);
`endif
        end else if (start) begin
            state    <= RUN;
            score    <= '0;
            level    <= '0;
            food_cnt <= '0;
            restart  <= 1'b1;
`ifdef SNAKE_CTRL_LIVES_EN
            lives    <= LIVES_W'(LIVES);
`endif
        end else if (state == RUN) begin
            // Food is credited even when a collision or pause lands in the same cycle.
            if (food_eaten) begin
                if (score != '1)
                    score <= score + SCORE_W'(1);
                if (food_wrap) begin
                    food_cnt <= '0;
                    if (level != LEVEL_W'(MAX_LEVEL))
                        level <= level + LEVEL_W'(1);
                end else begin
                    food_cnt <= food_cnt + FOOD_W'(1);
                end
            end
            if (collision) begin
`ifdef SNAKE_CTRL_LIVES_EN
                if (life_lost) begin
                    lives   <= lives - LIVES_W'(1);
                    restart <= 1'b1;
                end else begin
                    lives   <= '0;
                    state   <= OVER;
                end
`else
                state <= OVER;
`endif
            end else if (pause) begin
                state <= PAUSE;
            end
        end else if (state == PAUSE && pause) begin
            state <= RUN;
        end
    end

    // The seed counter runs in every play state so the captured value depends on human timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_cnt <= '0;
            seed     <= '0;
        end else begin
            seed_cnt <= (seed_cnt == SEED_W'(SEED_MOD - 1)) ? '0 : seed_cnt + SEED_W'(1);
            if (key_pressed)
                seed <= seed_cnt;
        end
    end

endmodule

// File: tb/tb_snake_ctrl.sv
// Self-checking bench for snake_ctrl: directed game scenarios with literal expectations,
// then randomized play compared every cycle against a behavioural game model.
module tb_snake_ctrl;

    localparam int TB_BASE      = 10;
    localparam int TB_STEP      = 2;
    localparam int TB_MIN       = 4;
    localparam int TB_FPL       = 2;
    localparam int TB_MAX_LEVEL = 9;
    localparam int TB_SCORE_W   = 3;
    localparam int TB_SEED_MOD  = 7;
    localparam int TB_LIVES     = 3;
    localparam int SCORE_MAX    = (1 << TB_SCORE_W) - 1;
`ifdef SNAKE_CTRL_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  pause;
    logic                  key_pressed;
    logic                  food_eaten;
    logic                  collision;
    logic                  step;
    logic                  restart;
    logic [1:0]            state;
    logic [TB_SCORE_W-1:0] score;
    logic [3:0]            level;
    logic [2:0]            seed;
`ifdef SNAKE_CTRL_LIVES_EN
    logic [1:0]            lives;
`endif

    snake_ctrl #(
        .TICK_BASE_CLK  (TB_BASE),
        .TICK_STEP_CLK  (TB_STEP),
        .TICK_MIN_CLK   (TB_MIN),
        .FOOD_PER_LEVEL (TB_FPL),
        .MAX_LEVEL      (TB_MAX_LEVEL),
        .SCORE_W        (TB_SCORE_W),
        .SEED_MOD       (TB_SEED_MOD),
        .LIVES          (TB_LIVES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .key_pressed (key_pressed),
        .food_eaten  (food_eaten),
        .collision   (collision),
        .step        (step),
        .restart     (restart),
        .state       (state),
        .score       (score),
        .level       (level),
        .seed        (seed)
`ifdef SNAKE_CTRL_LIVES_EN
        ,
        .lives       (lives)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural game model: plain integers, rules applied once per clock edge.
    int m_state, m_score, m_level, m_food, m_timer, m_lives, m_seed, m_seed_cnt;
    int m_step, m_restart;

    function automatic int period_of(input int lvl);
        int p;
        p = TB_BASE - lvl * TB_STEP;
        return (p < TB_MIN) ? TB_MIN : p;
    endfunction

    always @(posedge clk) begin
        int p;
        if (rst) begin
            m_state = 0; m_score = 0; m_level = 0; m_food = 0; m_timer = 0;
            m_lives = TB_LIVES; m_seed = 0; m_seed_cnt = 0; m_step = 0; m_restart = 0;
        end else begin
            if (key_pressed) m_seed = m_seed_cnt;
            m_seed_cnt = (m_seed_cnt + 1) % TB_SEED_MOD;
            m_step = 0;
            m_restart = 0;
            if (start) begin
                m_state = 1; m_score = 0; m_level = 0; m_food = 0; m_timer = 0;
                m_lives = TB_LIVES; m_restart = 1;
            end else if (m_state == 1) begin
                p = period_of(m_level);
                if (food_eaten) begin
                    if (m_score < SCORE_MAX) m_score++;
                    m_food++;
                    if (m_food == TB_FPL) begin
                        m_food = 0;
                        if (m_level < TB_MAX_LEVEL) m_level++;
                    end
                end
                if (collision) begin
                    if (LIVES_EN && m_lives > 1) begin
                        m_lives--; m_restart = 1; m_timer = 0;
                    end else begin
                        if (LIVES_EN) m_lives = 0;
                        m_state = 3;
                    end
                end else begin
                    if (pause) m_state = 2;
                    if (m_timer >= p - 1) begin
                        m_step = 1; m_timer = 0;
                    end else begin
                        m_timer++;
                    end
                end
            end else if (m_state == 2 && pause) begin
                m_state = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_state",   int'(state),   m_state);
            check("m_score",   int'(score),   m_score);
            check("m_level",   int'(level),   m_level);
            check("m_seed",    int'(seed),    m_seed);
            check("m_step",    int'(step),    m_step);
            check("m_restart", int'(restart), m_restart);
`ifdef SNAKE_CTRL_LIVES_EN
            check("m_lives",   int'(lives),   m_lives);
`endif
        end
    end

    task automatic drive(input bit s, input bit p, input bit k, input bit f, input bit c);
        start = s; pause = p; key_pressed = k; food_eaten = f; collision = c;
        @(negedge clk);
        start = 0; pause = 0; key_pressed = 0; food_eaten = 0; collision = 0;
    endtask

    // Waits for the next step pulse; returns the number of cycles waited.
    task automatic wait_step(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step !== 1'b1 && n < 40);
        if (step !== 1'b1) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1; start = 0; pause = 0; key_pressed = 0; food_eaten = 0; collision = 0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 0;

        // Reset values and seed capture (cycle 0 is this cycle)
        check("rst_state", int'(state), 0);
        check("rst_score", int'(score), 0);
        check("rst_step",  int'(step),  0);
        check("rst_seed",  int'(seed),  0);
        repeat (10) @(negedge clk);
        drive(0, 0, 1, 0, 0);
        check("seed_at_10", int'(seed), 3);
        repeat (2) @(negedge clk);
        drive(0, 0, 1, 0, 0);
        check("seed_at_13", int'(seed), 6);
        drive(0, 0, 1, 0, 0);
        check("seed_wrap_14", int'(seed), 0);

        // Start and level-0 step cadence
        drive(1, 0, 0, 0, 0);
        check("start_restart", int'(restart), 1);
        check("start_state",   int'(state),   1);
        check("step_r1",       int'(step),    0);
        for (int r = 2; r <= 31; r++) begin
            @(negedge clk);
            check("step_cadence", int'(step), (r == 11 || r == 21 || r == 31) ? 1 : 0);
        end

        // Pause four cycles after a step, hold, resume
        repeat (4) @(negedge clk);
        drive(0, 1, 0, 0, 0);
        check("paused_state", int'(state), 2);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            check("no_step_paused", int'(step), 0);
        end
        drive(0, 1, 0, 0, 0);
        check("resumed_state", int'(state), 1);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            check("step_after_resume", int'(step), (k == 6) ? 1 : 0);
        end

        // Food, level-up and period shortening
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check("score_2", int'(score), 2);
        check("level_1", int'(level), 1);
        wait_step("sync_l1", n);
        wait_step("period_l1", n);
        check("period_l1", n, 8);
        for (int k = 0; k < 6; k++) drive(0, 0, 0, 1, 0);
        check("level_4", int'(level), 4);
        wait_step("sync_l4", n);
        wait_step("period_l4", n);
        check("period_l4_clamped", n, 4);
        drive(0, 0, 0, 1, 0);
        check("score_saturated", int'(score), 7);
        check("level_still_4",   int'(level), 4);

        // Food and collision together, then lives / game over
        drive(1, 0, 0, 0, 0);
        check("restart_score", int'(score), 0);
        drive(0, 0, 0, 1, 1);
        check("food_with_collision", int'(score), 1);
`ifdef SNAKE_CTRL_LIVES_EN
        check("lives_2", int'(lives), 2);
        check("lives_2_state", int'(state), 1);
        check("lives_2_restart", int'(restart), 1);
        drive(0, 0, 0, 0, 1);
        check("lives_1", int'(lives), 1);
        check("lives_1_restart", int'(restart), 1);
        drive(0, 0, 0, 0, 1);
        check("lives_0", int'(lives), 0);
        check("lives_0_restart", int'(restart), 0);
`endif
        check("over_state", int'(state), 3);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 1);
        check("over_ignores_state", int'(state), 3);
        check("over_ignores_score", int'(score), 1);
        drive(1, 0, 0, 0, 0);
        check("restart_from_over_score", int'(score), 0);
        check("restart_from_over_state", int'(state), 1);
        check("restart_from_over_pulse", int'(restart), 1);

        // Mid-game reset: no restart pulse
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_state",   int'(state),   0);
        check("midrst_restart", int'(restart), 0);

        // Randomized play against the model
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom % 500) == 0;
            start       = ($urandom % 64) == 0;
            pause       = ($urandom % 16) == 0;
            key_pressed = ($urandom % 8) == 0;
            food_eaten  = ($urandom % 4) == 0;
            collision   = ($urandom % 24) == 0;
            @(negedge clk);
        end
        rst = 0; start = 0; pause = 0; key_pressed = 0; food_eaten = 0; collision = 0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
